// File: rtl/rd_ddr_fifo_conv.sv
`timescale 1ns/1ps
// rd_ddr_fifo_conv: single-clock show-ahead FIFO with power-of-2 width conversion (up, down or equal).
// Define RD_DDR_FIFO_CONV_FLAG_EN to build the sticky ovf/udf handshake-error flags.

module rd_ddr_fifo_conv #(
    parameter int WR_DATA_WIDTH = 256,
    parameter int RD_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH    = 9,
    parameter int AF_LEVEL      = 1536,
    localparam int MAXW = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH,
    localparam int MINW = (WR_DATA_WIDTH > RD_DATA_WIDTH) ? RD_DATA_WIDTH : WR_DATA_WIDTH,
    localparam int R    = MAXW / MINW,
    localparam int LW   = ADDR_WIDTH + $clog2(R) + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    output logic                     wr_vld,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    input  logic                     rd_en,
    output logic                     rd_vld,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
    output logic [LW-1:0]            level,
    output logic                     almost_full,
    output logic                     ovf,
    output logic                     udf
);

    localparam int RB      = $clog2(R);
    localparam int SW      = (RB > 0) ? RB : 1;
    localparam bit UP      = (WR_DATA_WIDTH < RD_DATA_WIDTH);
    localparam bit DOWN    = (WR_DATA_WIDTH > RD_DATA_WIDTH);
    localparam int WU      = UP ? 1 : R;
    localparam int RU      = DOWN ? 1 : R;
    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    // RAM plus prefetch word, plus up to R-1 narrow units of slack (partial pack or half-read word)
    localparam int LVL_MAX = (DEPTH + 1) * R + R - 1;
    localparam int WR_LIM  = LVL_MAX - WU;

    localparam logic [SW-1:0]       SLICE_ONE  = SW'(1);
    localparam logic [SW-1:0]       SLICE_ZERO = {SW{1'b0}};
    localparam logic [SW-1:0]       LAST_RD    = DOWN ? SW'(R - 1) : {SW{1'b0}};
    localparam logic [SW-1:0]       LAST_WR    = UP ? SW'(R - 1) : {SW{1'b0}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [LW-1:0]       WU_L       = LW'(WU);
    localparam logic [LW-1:0]       RU_L       = LW'(RU);
    localparam logic [LW-1:0]       LW_ZERO    = {LW{1'b0}};
    localparam logic [LW-1:0]       WR_LIM_L   = LW'(WR_LIM);

    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16) || ((MAXW % MINW) != 0)) begin : g_bad_ratio
        $error("rd_ddr_fifo_conv: width ratio must be a power of 2 in 1..16");
    end

    logic                     clr_s;
    logic                     wr_acc_s;
    logic                     rd_acc_s;
    logic                     ram_we_s;
    logic [MAXW-1:0]          ram_wdata_s;
    logic                     ram_re_s;
    logic                     pf_free_s;
    logic                     pf_load_s;

    logic [MAXW-1:0]          mem_r [DEPTH];
    logic [ADDR_WIDTH:0]      wptr_r;
    logic [ADDR_WIDTH:0]      rptr_r;
    logic [MAXW-1:0]          ram_q_r;
    logic                     ram_q_vld_r;
    logic [MAXW-1:0]          pf_r;
    logic                     pf_vld_r;
    logic [SW-1:0]            sidx_r;
    logic [RD_DATA_WIDTH-1:0] rd_data_r;
    logic [LW-1:0]            level_r;
    logic                     af_r;
    logic                     wr_vld_r;

    logic [MAXW-1:0]          pf_n_s;
    logic                     pf_vld_n_s;
    logic [SW-1:0]            sidx_n_s;
    logic                     ram_q_vld_n_s;
    logic [LW-1:0]            level_n_s;
    logic [RD_DATA_WIDTH-1:0] rd_data_n_s;

    assign clr_s    = rst | flush;
    assign wr_acc_s = wr_en & wr_vld_r & ~clr_s;
    assign rd_acc_s = rd_en & pf_vld_r & ~clr_s;

    if (UP) begin : g_pack
        logic [MAXW-WR_DATA_WIDTH-1:0] pack_r;
        logic [SW-1:0]                 wcnt_r;

        // accumulate narrow writes; the R-th one goes straight to RAM with the packed slices
        always_ff @(posedge clk) begin
            if (clr_s) begin
                pack_r <= {(MAXW - WR_DATA_WIDTH){1'b0}};
                wcnt_r <= SLICE_ZERO;
            end else if (wr_acc_s) begin
                wcnt_r <= wcnt_r + SLICE_ONE;
                if (wcnt_r != LAST_WR) begin
                    pack_r[wcnt_r*WR_DATA_WIDTH +: WR_DATA_WIDTH] <= wr_data;
                end
            end
        end

        assign ram_we_s    = wr_acc_s & (wcnt_r == LAST_WR);
        assign ram_wdata_s = {wr_data, pack_r};
    end else begin : g_direct
        assign ram_we_s    = wr_acc_s;
        assign ram_wdata_s = wr_data;
    end

    // ram_q is refilled whenever it is empty or moves into the prefetch word, so streaming has no bubble
    assign pf_free_s = rd_acc_s & (sidx_r == LAST_RD);
    assign pf_load_s = ram_q_vld_r & (~pf_vld_r | pf_free_s);
    assign ram_re_s  = ~clr_s & (wptr_r != rptr_r) & (~ram_q_vld_r | pf_load_s);

    // next state of the read pipeline and unpack index
    always_comb begin
        pf_n_s        = pf_r;
        pf_vld_n_s    = pf_vld_r;
        sidx_n_s      = sidx_r;
        ram_q_vld_n_s = ram_q_vld_r;
        if (pf_load_s) begin
            pf_n_s     = ram_q_r;
            pf_vld_n_s = 1'b1;
            sidx_n_s   = SLICE_ZERO;
        end else if (pf_free_s) begin
            pf_vld_n_s = 1'b0;
            sidx_n_s   = SLICE_ZERO;
        end else if (rd_acc_s) begin
            sidx_n_s   = sidx_r + SLICE_ONE;
        end else begin
            sidx_n_s   = sidx_r;
        end
        if (ram_re_s) begin
            ram_q_vld_n_s = 1'b1;
        end else if (pf_load_s) begin
            ram_q_vld_n_s = 1'b0;
        end else begin
            ram_q_vld_n_s = ram_q_vld_r;
        end
    end

    assign level_n_s   = level_r + (wr_acc_s ? WU_L : LW_ZERO) - (rd_acc_s ? RU_L : LW_ZERO);
    assign rd_data_n_s = pf_n_s[sidx_n_s*RD_DATA_WIDTH +: RD_DATA_WIDTH];

    // storage array with registered read port
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[wptr_r[ADDR_WIDTH-1:0]] <= ram_wdata_s;
        end
        if (ram_re_s) begin
            ram_q_r <= mem_r[rptr_r[ADDR_WIDTH-1:0]];
        end
    end

    // pointers, prefetch stage, fill level and registered outputs
    always_ff @(posedge clk) begin
        if (clr_s) begin
            wptr_r      <= {(ADDR_WIDTH + 1){1'b0}};
            rptr_r      <= {(ADDR_WIDTH + 1){1'b0}};
            ram_q_vld_r <= 1'b0;
            pf_r        <= {MAXW{1'b0}};
            pf_vld_r    <= 1'b0;
            sidx_r      <= SLICE_ZERO;
            rd_data_r   <= {RD_DATA_WIDTH{1'b0}};
            level_r     <= LW_ZERO;
            af_r        <= 1'b0;
            wr_vld_r    <= 1'b0;
        end else begin
            if (ram_we_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (ram_re_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            ram_q_vld_r <= ram_q_vld_n_s;
            pf_r        <= pf_n_s;
            pf_vld_r    <= pf_vld_n_s;
            sidx_r      <= sidx_n_s;
            rd_data_r   <= rd_data_n_s;
            level_r     <= level_n_s;
            af_r        <= (32'(level_n_s) >= AF_LEVEL);
            wr_vld_r    <= (level_n_s <= WR_LIM_L);
        end
    end

`ifdef RD_DDR_FIFO_CONV_FLAG_EN
    logic ovf_r;
    logic udf_r;

    // sticky handshake-violation flags
    always_ff @(posedge clk) begin
        if (clr_s) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | (wr_en & ~wr_vld_r);
            udf_r <= udf_r | (rd_en & ~pf_vld_r);
        end
    end

    assign ovf = ovf_r;
    assign udf = udf_r;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    assign wr_vld      = wr_vld_r;
    assign rd_vld      = pf_vld_r;
    assign rd_data     = rd_data_r;
    assign level       = level_r;
    assign almost_full = af_r;

endmodule

// File: tb/tb_rd_ddr_fifo_conv.sv
`timescale 1ns/1ps
// Directed bench for rd_ddr_fifo_conv: 256->64 default, 64->256 and 32->32 instances share clk/rst/flush.

module tb_rd_ddr_fifo_conv;

`ifdef RD_DDR_FIFO_CONV_FLAG_EN
    localparam logic FLAGS = 1'b1;
`else
    localparam logic FLAGS = 1'b0;
`endif

    logic clk, rst, flush;

    logic         dn_wr_en, dn_wr_vld, dn_rd_en, dn_rd_vld, dn_af, dn_ovf, dn_udf;
    logic [255:0] dn_wdata;
    logic [63:0]  dn_rdata;
    logic [12:0]  dn_level;

    logic         up_wr_en, up_wr_vld, up_rd_en, up_rd_vld, up_af, up_ovf, up_udf;
    logic [63:0]  up_wdata;
    logic [255:0] up_rdata;
    logic [7:0]   up_level;

    logic         eq_wr_en, eq_wr_vld, eq_rd_en, eq_rd_vld, eq_af, eq_ovf, eq_udf;
    logic [31:0]  eq_wdata;
    logic [31:0]  eq_rdata;
    logic [5:0]   eq_level;

    int n_vec;
    int n_err;

    rd_ddr_fifo_conv u_dn (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(dn_wr_en), .wr_vld(dn_wr_vld), .wr_data(dn_wdata),
        .rd_en(dn_rd_en), .rd_vld(dn_rd_vld), .rd_data(dn_rdata),
        .level(dn_level), .almost_full(dn_af), .ovf(dn_ovf), .udf(dn_udf)
    );

    rd_ddr_fifo_conv #(.WR_DATA_WIDTH(64), .RD_DATA_WIDTH(256), .ADDR_WIDTH(4), .AF_LEVEL(40)) u_up (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(up_wr_en), .wr_vld(up_wr_vld), .wr_data(up_wdata),
        .rd_en(up_rd_en), .rd_vld(up_rd_vld), .rd_data(up_rdata),
        .level(up_level), .almost_full(up_af), .ovf(up_ovf), .udf(up_udf)
    );

    rd_ddr_fifo_conv #(.WR_DATA_WIDTH(32), .RD_DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_LEVEL(12)) u_eq (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_en(eq_wr_en), .wr_vld(eq_wr_vld), .wr_data(eq_wdata),
        .rd_en(eq_rd_en), .rd_vld(eq_rd_vld), .rd_data(eq_rdata),
        .level(eq_level), .almost_full(eq_af), .ovf(eq_ovf), .udf(eq_udf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before 400000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input int i, input logic [15:0] tag);
        logic [255:0] v;
        for (int k = 0; k < 4; k++) begin
            v[k*64 +: 64] = {tag, 16'(k), 32'(i)};
        end
        return v;
    endfunction

    initial begin
        logic [255:0] w;
        logic [31:0]  sb[$];
        logic [31:0]  exp32;
        int acc, seq, ncons;

        n_vec = 0; n_err = 0;
        rst = 1'b1; flush = 1'b0;
        dn_wr_en = 1'b0; dn_rd_en = 1'b0; dn_wdata = '0;
        up_wr_en = 1'b0; up_rd_en = 1'b0; up_wdata = '0;
        eq_wr_en = 1'b0; eq_rd_en = 1'b0; eq_wdata = '0;
        tick(); tick();

        // reset state
        check("rst_dn_wr_vld", dn_wr_vld, 0);
        check("rst_dn_rd_vld", dn_rd_vld, 0);
        check("rst_dn_rd_data", dn_rdata, 0);
        check("rst_dn_level", dn_level, 0);
        check("rst_dn_af", dn_af, 0);
        check("rst_dn_ovf", dn_ovf, 0);
        check("rst_dn_udf", dn_udf, 0);
        check("rst_up_rd_data", up_rdata, 0);
        check("rst_eq_wr_vld", eq_wr_vld, 0);
        rst = 1'b0;
        tick();
        check("rel_dn_wr_vld", dn_wr_vld, 1);
        check("rel_up_wr_vld", up_wr_vld, 1);

        // 1: one wide word unpacks into four slices, low slice first
        w = mk(7, 16'hC0DE);
        dn_wdata = w; dn_wr_en = 1'b1;
        tick();
        dn_wr_en = 1'b0;
        check("t1_level_after_wr", dn_level, 4);
        check("t1_rd_vld_n", dn_rd_vld, 0);
        tick();
        check("t1_rd_vld_n1", dn_rd_vld, 0);
        tick();
        check("t1_rd_vld_n2", dn_rd_vld, 1);
        check("t1_slice0", dn_rdata, w[63:0]);
        check("t1_hold_slice0", dn_rdata, w[63:0]);
        dn_rd_en = 1'b1;
        tick();
        check("t1_slice1", dn_rdata, w[127:64]);
        check("t1_level3", dn_level, 3);
        tick();
        check("t1_slice2", dn_rdata, w[191:128]);
        tick();
        check("t1_slice3", dn_rdata, w[255:192]);
        check("t1_level1", dn_level, 1);
        tick();
        dn_rd_en = 1'b0;
        check("t1_level0", dn_level, 0);
        check("t1_empty", dn_rd_vld, 0);

        // 3: upsizing packs four narrow writes, first write in the low slice
        up_wr_en = 1'b1;
        up_wdata = 64'hA; tick();
        up_wdata = 64'hB; tick();
        up_wdata = 64'hC; tick();
        check("t3_partial_level", up_level, 3);
        check("t3_partial_rd_vld", up_rd_vld, 0);
        up_wdata = 64'hD; tick();
        up_wr_en = 1'b0;
        check("t3_level4", up_level, 4);
        tick();
        check("t3_rd_vld_n1", up_rd_vld, 0);
        tick();
        check("t3_rd_vld_n2", up_rd_vld, 1);
        check("t3_packed", up_rdata, {64'hD, 64'hC, 64'hB, 64'hA});
        up_rd_en = 1'b1;
        tick();
        up_rd_en = 1'b0;
        check("t3_level_after_rd", up_level, 0);
        check("t3_rd_vld_after_rd", up_rd_vld, 0);

        // 2: fill with no reads; exactly 513 wide words fit
        acc = 0;
        dn_wr_en = 1'b1;
        for (int i = 0; i < 520; i++) begin
            logic pre;
            dn_wdata = mk(acc, 16'hBEEF);
            pre = dn_wr_vld;
            tick();
            if (pre) acc++;
            check("t2_level", dn_level, 256'(acc * 4));
            check("t2_af", dn_af, 256'(acc * 4 >= 1536));
        end
        dn_wr_en = 1'b0;
        check("t2_accepted", 256'(acc), 513);
        check("t2_wr_vld_full", dn_wr_vld, 0);
        check("t2_level_full", dn_level, 2052);
        check("t2_af_full", dn_af, 1);
        check("t2_ovf", dn_ovf, FLAGS);
        check("t2_head", dn_rdata, {16'hBEEF, 16'd0, 32'd0});
        dn_rd_en = 1'b1;
        tick();
        dn_rd_en = 1'b0;
        check("t2_wr_vld_after_rd", dn_wr_vld, 1);
        check("t2_level_after_rd", dn_level, 2051);
        check("t2_next_slice", dn_rdata, {16'hBEEF, 16'd1, 32'd0});

        // 4: flush with 100 words stored downstream and a partial pack upstream
        flush = 1'b1; tick(); flush = 1'b0; tick();
        dn_wr_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            dn_wdata = mk(i, 16'hDEAD);
            up_wr_en = (i < 2);
            up_wdata = (i == 0) ? 64'hEE : 64'hFF;
            tick();
        end
        dn_wr_en = 1'b0; up_wr_en = 1'b0;
        check("t4_dn_level_pre", dn_level, 400);
        check("t4_up_level_pre", up_level, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_dn_level", dn_level, 0);
        check("t4_dn_rd_vld", dn_rd_vld, 0);
        check("t4_up_level", up_level, 0);
        check("t4_up_rd_vld", up_rd_vld, 0);
        check("t4_dn_wr_vld_in_flush", dn_wr_vld, 0);
        check("t4_dn_ovf", dn_ovf, 0);
        tick();
        check("t4_dn_wr_vld", dn_wr_vld, 1);
        check("t4_up_wr_vld", up_wr_vld, 1);
        check("t4_dn_udf", dn_udf, 0);
        w = mk(9, 16'hF00D);
        dn_wdata = w; dn_wr_en = 1'b1;
        up_wr_en = 1'b1; up_wdata = 64'h11;
        tick();
        dn_wr_en = 1'b0;
        up_wdata = 64'h22; tick();
        up_wdata = 64'h33; tick();
        up_wdata = 64'h44; tick();
        up_wr_en = 1'b0;
        tick(); tick();
        check("t4_up_fresh", up_rdata, {64'h44, 64'h33, 64'h22, 64'h11});
        check("t4_up_level", up_level, 4);
        check("t4_dn_fresh0", dn_rdata, w[63:0]);
        check("t4_dn_level4", dn_level, 4);
        up_rd_en = 1'b1; dn_rd_en = 1'b1;
        tick();
        up_rd_en = 1'b0;
        check("t4_up_drained", up_level, 0);
        check("t4_dn_fresh1", dn_rdata, w[127:64]);
        tick();
        check("t4_dn_fresh2", dn_rdata, w[191:128]);
        tick();
        check("t4_dn_fresh3", dn_rdata, w[255:192]);
        tick();
        dn_rd_en = 1'b0;
        check("t4_dn_drained", dn_rd_vld, 0);

        // 5: equal widths, full FIFO streamed for 1000 cycles
        seq = 0;
        eq_wr_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            eq_wdata = 32'h5A00_0000 + 32'(seq);
            if (eq_wr_vld) begin
                sb.push_back(eq_wdata);
                seq++;
            end
            tick();
        end
        check("t5_fill_count", 256'(seq), 17);
        check("t5_fill_level", eq_level, 17);
        check("t5_fill_wr_vld", eq_wr_vld, 0);
        eq_rd_en = 1'b1;
        acc = 0; ncons = 0;
        for (int i = 0; i < 1000; i++) begin
            eq_wdata = 32'h5A00_0000 + 32'(seq);
            if (eq_wr_vld) begin
                sb.push_back(eq_wdata);
                seq++;
                acc++;
            end
            if (eq_rd_vld) begin
                exp32 = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
                check("t5_data", eq_rdata, exp32);
                ncons++;
            end
            tick();
            check("t5_level", eq_level, 16);
        end
        check("t5_accepts", 256'(acc), 999);
        check("t5_consumes", 256'(ncons), 1000);

        // 6: reset while streaming discards the write of the reset cycle
        eq_wdata = 32'hBAD0_0001;
        rst = 1'b1;
        tick();
        rst = 1'b0; eq_wr_en = 1'b0; eq_rd_en = 1'b0;
        check("t6_level_rst", eq_level, 0);
        check("t6_rd_vld_rst", eq_rd_vld, 0);
        check("t6_wr_vld_rst", eq_wr_vld, 0);
        tick();
        check("t6_wr_vld_rel", eq_wr_vld, 1);
        check("t6_level_rel", eq_level, 0);
        tick();
        check("t6_no_ghost", eq_rd_vld, 0);
        check("t6_dn_empty", dn_level, 0);
        eq_rd_en = 1'b1;
        tick();
        eq_rd_en = 1'b0;
        check("t6_udf", eq_udf, FLAGS);
        check("t6_level_still0", eq_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
